// File: rtl/a25_wb_slave_pkg.sv
// Shared types and widths for the Amber 128-bit wishbone memory responder.
package a25_wb_slave_pkg;

    localparam int unsigned WB_DAT_W   = 128;
    localparam int unsigned WB_SEL_W   = 16;
    localparam int unsigned WB_ADR_W   = 32;
    localparam int unsigned WAIT_CNT_W = 4;

    // Responder FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2,
        ERR  = 2'd3
    } state_t;

endpackage

// File: rtl/a25_wb_mem_array.sv
// DEPTH_LINES x 128-bit synchronous RAM with per-byte write enables and one
// registered read port.
//   clk, rst_n : clock, async active-low reset (read register only)
//   idx        : line index shared by read and write
//   wr_en      : write strobe; bytes with wr_sel[n]=1 take wr_dat
//   rd_en      : load read register with mem[idx]; otherwise it loads zero
//   rd_dat     : registered read data
module a25_wb_mem_array
    import a25_wb_slave_pkg::*;
#(
    parameter int unsigned DEPTH_LINES = 256,
    localparam int unsigned IDX_W      = $clog2(DEPTH_LINES)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [IDX_W-1:0]    idx,
    input  logic                wr_en,
    input  logic [WB_SEL_W-1:0] wr_sel,
    input  logic [WB_DAT_W-1:0] wr_dat,
    input  logic                rd_en,
    output logic [WB_DAT_W-1:0] rd_dat
);

    logic [WB_DAT_W-1:0] mem [DEPTH_LINES];

    // Byte-masked write; contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < int'(WB_SEL_W); b++) begin
                if (wr_sel[b]) begin
                    mem[idx][8*b +: 8] <= wr_dat[8*b +: 8];
                end
            end
        end
    end

    // Read register is zero whenever no read is being returned
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_dat <= '0;
        end else if (rd_en) begin
            rd_dat <= mem[idx];
        end else begin
            rd_dat <= '0;
        end
    end

endmodule

// File: rtl/a25_wishbone_mem_slave.sv
// Wishbone B3 classic-cycle responder serving single reads/writes from an
// on-chip byte-enabled memory, with configurable read/write wait states and
// error termination for out-of-window addresses.
//   i_clk, i_rst_n : clock, async active-low reset
//   i_wb_cyc/stb   : request present when both high
//   i_wb_we        : 1=write, 0=read
//   i_wb_adr       : byte address, bits [3:0] ignored
//   i_wb_sel       : byte enables for writes
//   i_wb_dat       : write data
//   o_wb_dat       : read data, non-zero only during a read ack
//   o_wb_ack       : normal termination pulse
//   o_wb_err       : error termination pulse
module a25_wishbone_mem_slave
    import a25_wb_slave_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
    parameter int unsigned DEPTH_LINES = 256,
    parameter int unsigned READ_WAIT   = 1,
    parameter int unsigned WRITE_WAIT  = 0
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_wb_cyc,
    input  logic                i_wb_stb,
    input  logic                i_wb_we,
    input  logic [WB_ADR_W-1:0] i_wb_adr,
    input  logic [WB_SEL_W-1:0] i_wb_sel,
    input  logic [WB_DAT_W-1:0] i_wb_dat,
    output logic [WB_DAT_W-1:0] o_wb_dat,
    output logic                o_wb_ack,
    output logic                o_wb_err
);

    localparam int unsigned IDX_W  = $clog2(DEPTH_LINES);
    localparam int unsigned TAG_LO = 4 + IDX_W;

    localparam logic [WAIT_CNT_W-1:0] RD_LOAD =
        (READ_WAIT == 0) ? '0 : WAIT_CNT_W'(READ_WAIT - 1);
    localparam logic [WAIT_CNT_W-1:0] WR_LOAD =
        (WRITE_WAIT == 0) ? '0 : WAIT_CNT_W'(WRITE_WAIT - 1);
    localparam logic RD_NOWAIT = (READ_WAIT == 0);
    localparam logic WR_NOWAIT = (WRITE_WAIT == 0);

    state_t                state;
    state_t                state_nxt;
    logic [WAIT_CNT_W-1:0] cnt;
    logic [WAIT_CNT_W-1:0] cnt_nxt;

    logic             request_c;
    logic             hit_c;
    logic             no_wait_c;
    logic [IDX_W-1:0] idx_c;
    logic             mem_wr_c;
    logic             mem_rd_c;
    logic             unused_adr_lsb;

    assign request_c      = i_wb_cyc & i_wb_stb;
    assign hit_c          = (i_wb_adr[WB_ADR_W-1:TAG_LO] == ADDR_BASE[WB_ADR_W-1:TAG_LO]);
    assign no_wait_c      = i_wb_we ? WR_NOWAIT : RD_NOWAIT;
    assign idx_c          = i_wb_adr[TAG_LO-1:4];
    assign unused_adr_lsb = ^i_wb_adr[3:0];

    // Next-state and wait-counter logic
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        unique case (state)
            IDLE: begin
                if (request_c) begin
                    if (!hit_c) begin
                        state_nxt = ERR;
                    end else if (no_wait_c) begin
                        state_nxt = ACK;
                    end else begin
                        state_nxt = WAIT;
                        cnt_nxt   = i_wb_we ? WR_LOAD : RD_LOAD;
                    end
                end
            end
            WAIT: begin
                if (!request_c) begin
                    // master abandoned the transfer
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == '0) begin
                    state_nxt = ACK;
                end else begin
                    cnt_nxt = cnt - WAIT_CNT_W'(1);
                end
            end
            ACK:     state_nxt = IDLE;
            ERR:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State, counter and registered terminations
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            o_wb_ack <= 1'b0;
            o_wb_err <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            o_wb_ack <= (state_nxt == ACK);
            o_wb_err <= (state_nxt == ERR);
        end
    end

    // Read line is fetched on the edge entering ACK; write commits at the end of ACK
    assign mem_rd_c = (state_nxt == ACK) && !i_wb_we;
    assign mem_wr_c = (state == ACK) && i_wb_we;

    a25_wb_mem_array #(
        .DEPTH_LINES (DEPTH_LINES)
    ) u_mem (
        .clk    (i_clk),
        .rst_n  (i_rst_n),
        .idx    (idx_c),
        .wr_en  (mem_wr_c),
        .wr_sel (i_wb_sel),
        .wr_dat (i_wb_dat),
        .rd_en  (mem_rd_c),
        .rd_dat (o_wb_dat)
    );

endmodule

// File: tb/tb_a25_wishbone_mem_slave.sv
// Scoreboard bench for a25_wishbone_mem_slave: the driver pushes expected
// terminations computed from a line-array model; a negedge monitor pops and
// compares whenever ack or err is presented.
module tb_a25_wishbone_mem_slave;

    localparam int unsigned RW = 3;
    localparam int unsigned WW = 0;

    typedef struct {
        bit           is_err;
        bit           is_read;
        logic [127:0] data;
        int           req_edge;
        int           lat;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         cyc = 1'b0;
    logic         stb = 1'b0;
    logic         we = 1'b0;
    logic [31:0]  adr = '0;
    logic [15:0]  sel = '0;
    logic [127:0] dat = '0;
    logic [127:0] rdat;
    logic         ack;
    logic         err;

    int           cyc_cnt = 0;
    int           n_cmp = 0;
    int           n_fail = 0;
    bit           prev_ack = 1'b0;
    exp_t         expq[$];
    exp_t         me;
    logic [127:0] model [256];

    a25_wishbone_mem_slave #(
        .ADDR_BASE   (32'h0000_0000),
        .DEPTH_LINES (256),
        .READ_WAIT   (RW),
        .WRITE_WAIT  (WW)
    ) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_wb_cyc (cyc),
        .i_wb_stb (stb),
        .i_wb_we  (we),
        .i_wb_adr (adr),
        .i_wb_sel (sel),
        .i_wb_dat (dat),
        .o_wb_dat (rdat),
        .o_wb_ack (ack),
        .o_wb_err (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    function automatic logic [127:0] merge(input logic [127:0] old,
                                           input logic [127:0] d,
                                           input logic [15:0]  s);
        logic [127:0] r;
        r = old;
        for (int b = 0; b < 16; b++) begin
            if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        end
        return r;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Monitor: compare each termination against the oldest expectation
    always @(negedge clk) begin
        if (rst_n && (ack || err)) begin
            n_cmp++;
            if (ack && err) begin
                n_fail++;
                $display("FAIL both_term: ack=%0b err=%0b, required not both", ack, err);
            end
            n_cmp++;
            if (!(cyc && stb)) begin
                n_fail++;
                $display("FAIL term_without_req: cyc=%0b stb=%0b, required both 1", cyc, stb);
            end
            if (ack) begin
                n_cmp++;
                if (prev_ack) begin
                    n_fail++;
                    $display("FAIL ack_separation: ack high two cycles running, required a low cycle");
                end
            end
            if (expq.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_term: ack=%0b err=%0b at cycle %0d, required none", ack, err, cyc_cnt);
            end else begin
                me = expq.pop_front();
                n_cmp++;
                if (err != me.is_err) begin
                    n_fail++;
                    $display("FAIL term_kind: err=%0b ack=%0b, required err=%0b", err, ack, me.is_err);
                end
                n_cmp++;
                if (cyc_cnt - me.req_edge + 1 != me.lat) begin
                    n_fail++;
                    $display("FAIL latency: got %0d cycles, required %0d", cyc_cnt - me.req_edge + 1, me.lat);
                end
                if (me.is_read || me.is_err) begin
                    n_cmp++;
                    if (rdat !== me.data) begin
                        n_fail++;
                        $display("FAIL read_data: got %h, required %h", rdat, me.data);
                    end
                end
            end
        end
        prev_ack = ack;
    end

    // Issue one request (called at posedge+1 with the DUT idle) and wait for its end
    task automatic do_req(input logic w, input logic [31:0] a, input logic [15:0] s,
                          input logic [127:0] d, input int gap);
        exp_t e;
        int   n;
        int   k;
        int   li;
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; dat = d;
        li = int'(a[11:4]);
        e.req_edge = cyc_cnt + 1;
        e.is_err   = (a[31:12] != 20'h0);
        e.is_read  = !w && !e.is_err;
        e.data     = '0;
        if (e.is_err) begin
            e.lat = 1;
        end else if (w) begin
            e.lat = WW + 1;
            model[li] = merge(model[li], d, s);
        end else begin
            e.lat  = RW + 1;
            e.data = model[li];
        end
        expq.push_back(e);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(ack || err) && n < 40);
        if (n >= 40) begin
            n_cmp++;
            n_fail++;
            $display("FAIL timeout: no termination for adr %h within 40 cycles, required one", a);
        end
        @(posedge clk); #1;
        if (gap > 0) begin
            k = $urandom_range(0, 2);
            cyc = (k == 2);
            stb = (k == 1);
            repeat (gap) begin @(posedge clk); #1; end
        end
    endtask

    initial begin
        logic [127:0] d;
        logic [31:0]  a;

        // Reset held with a request present: everything stays quiet
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h0; sel = 16'hFFFF;
        d = rnd128(); dat = d;
        repeat (3) begin
            @(negedge clk);
            n_cmp++;
            if (ack !== 1'b0 || err !== 1'b0 || rdat !== '0) begin
                n_fail++;
                $display("FAIL reset_quiet: ack=%0b err=%0b dat=%h, required 0/0/0", ack, err, rdat);
            end
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        do_req(1'b1, 32'h0, 16'hFFFF, d, 0);

        // Full-line write then read
        do_req(1'b1, 32'h20, 16'hFFFF, 128'h0123456789ABCDEF0123456789ABCDEF, 1);
        do_req(1'b0, 32'h20, 16'h0000, '0, 1);

        // Byte enables
        do_req(1'b1, 32'h10, 16'hFFFF, {16{8'hAA}}, 0);
        do_req(1'b1, 32'h10, 16'h000F, {16{8'h55}}, 0);
        do_req(1'b0, 32'h10, 16'hFFFF, '0, 1);

        // Out-of-window write aliases line 0 and must not touch it
        do_req(1'b1, 32'h0000_1000, 16'hFFFF, rnd128(), 1);
        do_req(1'b0, 32'h0, 16'hFFFF, '0, 0);

        // Abort a read after one cycle in WAIT, then an immediate read
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h20; sel = 16'hFFFF;
        @(posedge clk);
        @(posedge clk); #1;
        stb = 1'b0;
        @(posedge clk); #1;
        do_req(1'b0, 32'h20, 16'hFFFF, '0, 0);

        // Back-to-back writes, then readback
        for (int i = 0; i < 4; i++) begin
            do_req(1'b1, 32'(i * 16), 16'hFFFF, rnd128(), 0);
        end
        for (int i = 0; i < 4; i++) begin
            do_req(1'b0, 32'(i * 16), 16'hFFFF, '0, 0);
        end

        // Fill remaining working lines
        for (int i = 4; i < 16; i++) begin
            do_req(1'b1, 32'(i * 16), 16'hFFFF, rnd128(), 0);
        end

        // Reset during the ack cycle of a write: write is lost
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h50; sel = 16'hFFFF; dat = rnd128();
        @(posedge clk); #2;
        rst_n = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (ack !== 1'b0 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_midxfer: ack=%0b err=%0b, required 0/0", ack, err);
        end
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0; rst_n = 1'b1;
        @(posedge clk); #1;
        do_req(1'b0, 32'h50, 16'hFFFF, '0, 1);

        // Randomized traffic over lines 0..15 with occasional misses
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                a = {20'($urandom_range(1, 20'hFFFFF)), 12'($urandom)};
            end else begin
                a = {24'h0, 4'($urandom_range(0, 15)), 4'($urandom)};
            end
            do_req(1'($urandom_range(0, 1)), a, 16'($urandom), rnd128(),
                   $urandom_range(0, 2));
        end
        cyc = 1'b0; stb = 1'b0;
        repeat (10) @(posedge clk);

        n_cmp++;
        if (expq.size() != 0) begin
            n_fail++;
            $display("FAIL pending_terms: %0d outstanding, required 0", expq.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
